uvma_rvfi_retire_buf: RTL and testbench

// - Multi-channel successor of the single-port RVFI instruction capture: accepts up to NRET retirements per clk

---
 rtl/uvma_rvfi_pkg.sv | 24 ++
 rtl/uvma_rvfi_retire_compact.sv | 36 +++
 rtl/uvma_rvfi_retire_buf.sv | 123 ++++++++++++
 tb/tb_uvma_rvfi_retire_buf.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uvma_rvfi_pkg.sv
// Shared types for the RVFI multi-retirement capture buffer.
// The record width follows the package defaults DEFAULT_XLEN / DEFAULT_ILEN.
package uvma_rvfi_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int DEFAULT_ILEN = 32;
  localparam int DEFAULT_NRET = 2;
  localparam int ORDER_WL     = 64;

  typedef struct packed {
    logic [ORDER_WL-1:0]       order;
    logic [DEFAULT_ILEN-1:0]   insn;
    logic                      trap;
    logic                      intr;
    logic [DEFAULT_XLEN-1:0]   pc_rdata;
    logic [DEFAULT_XLEN-1:0]   pc_wdata;
    logic [4:0]                rd1_addr;
    logic [DEFAULT_XLEN-1:0]   rd1_wdata;
    logic [DEFAULT_XLEN-1:0]   mem_addr;
    logic [DEFAULT_XLEN/8-1:0] mem_rmask;
    logic [DEFAULT_XLEN/8-1:0] mem_wmask;
  } rvfi_retire_rec_t;

endpackage

// File: rtl/uvma_rvfi_retire_compact.sv
// Packs the valid retirement channels to the low slots, keeping channel order,
// and reports how many were valid. Purely combinational.
module uvma_rvfi_retire_compact
  import uvma_rvfi_pkg::*;
#(
  parameter  int NRET = DEFAULT_NRET,
  localparam int CW   = $clog2(NRET + 1)
) (
  input  logic [NRET-1:0]              valid,
  input  rvfi_retire_rec_t [NRET-1:0]  rec,
  output rvfi_retire_rec_t [NRET-1:0]  packed_rec,
  output logic [CW-1:0]                count
);

  logic [CW-1:0] pos [NRET];
  logic [CW-1:0] acc;

  // pos[i] is the number of valid channels older than channel i, i.e. its packed slot
  always_comb begin
    acc        = '0;
    packed_rec = '0;
    for (int i = 0; i < NRET; i++) begin
      pos[i] = acc;
      acc    = acc + CW'(valid[i]);
    end
    for (int j = 0; j < NRET; j++) begin
      for (int i = 0; i < NRET; i++) begin
        if (valid[i] && (pos[i] == CW'(j))) begin
          packed_rec[j] = rec[i];
        end
      end
    end
    count = acc;
  end

endmodule

// File: rtl/uvma_rvfi_retire_buf.sv
// Monitor-side retirement buffer: captures up to NRET retirements per cycle and
// replays them one per cycle in program order. Statistics ports: UVMA_RVFI_RETIRE_BUF_STATS_EN.
module uvma_rvfi_retire_buf
  import uvma_rvfi_pkg::*;
#(
  parameter  int NRET  = DEFAULT_NRET,
  parameter  int DEPTH = 16,
  localparam int LW    = $clog2(DEPTH) + 1,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(NRET + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [NRET-1:0]              in_valid,
  input  rvfi_retire_rec_t [NRET-1:0]  in_rec,
  output logic                         out_valid,
  input  logic                         out_ready,
  output rvfi_retire_rec_t             out_rec,
  output logic [LW-1:0]                level,
  output logic                         overflow,
  output logic                         order_err
`ifdef UVMA_RVFI_RETIRE_BUF_STATS_EN
  ,
  output logic [63:0]                  stat_retired,
  output logic [LW-1:0]                stat_max_level,
  output logic [31:0]                  stat_dropped
`endif
);

  // Handshake: a record leaves the buffer on a rising clk edge where out_valid && out_ready;
  // out_valid never depends on out_ready and the input side is never back-pressured.

  rvfi_retire_rec_t            mem [DEPTH];
  rvfi_retire_rec_t [NRET-1:0] cmp_rec;
  logic [CW-1:0]               k;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [ORDER_WL-1:0]         exp_order;
  logic                        exp_vld;
  logic                        pop;
  logic [LW-1:0]               free;
  logic [LW-1:0]               n_store;
  logic [LW-1:0]               n_dropped;
  logic [LW-1:0]               level_next;

  uvma_rvfi_retire_compact #(.NRET(NRET)) u_compact (
    .valid      (in_valid),
    .rec        (in_rec),
    .packed_rec (cmp_rec),
    .count      (k)
  );

  assign out_valid = (level != '0);
  assign out_rec   = mem[rd_ptr];
  assign pop       = out_valid && out_ready;

  // The slot freed by this cycle's pop is available to this cycle's push
  always_comb begin
    free       = LW'(DEPTH) - level + LW'(pop);
    n_store    = (LW'(k) > free) ? free : LW'(k);
    n_dropped  = LW'(k) - n_store;
    level_next = level + n_store - LW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
      exp_order <= '0;
      exp_vld   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
      exp_order <= '0;
      exp_vld   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NRET; i++) begin
        if (LW'(i) < n_store) mem[wr_ptr + PW'(i)] <= cmp_rec[i];
      end
      wr_ptr    <= wr_ptr + PW'(n_store);
      rd_ptr    <= rd_ptr + PW'(pop);
      level     <= level_next;
      if (n_dropped != '0) overflow <= 1'b1;
      // Pulse follows the offending pop by one cycle; the checker then resyncs to it
      order_err <= pop && exp_vld && (out_rec.order != exp_order);
      if (pop) begin
        exp_order <= out_rec.order + 1'b1;
        exp_vld   <= 1'b1;
      end
    end
  end

`ifdef UVMA_RVFI_RETIRE_BUF_STATS_EN
  logic [32:0] dropped_sum;
  assign dropped_sum = {1'b0, stat_dropped} + 33'(n_dropped);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_retired   <= '0;
      stat_max_level <= '0;
      stat_dropped   <= '0;
    end else if (flush) begin
      stat_retired   <= '0;
      stat_max_level <= '0;
      stat_dropped   <= '0;
    end else begin
      stat_retired <= stat_retired + 64'(pop);
      if (level_next > stat_max_level) stat_max_level <= level_next;
      stat_dropped <= dropped_sum[32] ? 32'hffff_ffff : dropped_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_uvma_rvfi_retire_buf.sv
// Directed bench for uvma_rvfi_retire_buf at NRET=2, DEPTH=16.
module tb_uvma_rvfi_retire_buf;
  import uvma_rvfi_pkg::*;

  localparam int NRET  = 2;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic                        flush;
  logic [NRET-1:0]             in_valid;
  rvfi_retire_rec_t [NRET-1:0] in_rec;
  logic                        out_valid;
  logic                        out_ready;
  rvfi_retire_rec_t            out_rec;
  logic [LW-1:0]               level;
  logic                        overflow;
  logic                        order_err;
`ifdef UVMA_RVFI_RETIRE_BUF_STATS_EN
  logic [63:0]                 stat_retired;
  logic [LW-1:0]               stat_max_level;
  logic [31:0]                 stat_dropped;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uvma_rvfi_retire_buf #(.NRET(NRET), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_rec    (in_rec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rec   (out_rec),
    .level     (level),
    .overflow  (overflow),
    .order_err (order_err)
`ifdef UVMA_RVFI_RETIRE_BUF_STATS_EN
    ,
    .stat_retired   (stat_retired),
    .stat_max_level (stat_max_level),
    .stat_dropped   (stat_dropped)
`endif
  );

  function automatic rvfi_retire_rec_t mk_rec(input logic [63:0] o);
    rvfi_retire_rec_t r;
    r           = '0;
    r.order     = o;
    r.insn      = 32'h0000_0013 + o[31:0];
    r.pc_rdata  = 32'h8000_0000 + (o[31:0] << 2);
    r.pc_wdata  = r.pc_rdata + 32'd4;
    r.rd1_addr  = o[4:0];
    r.rd1_wdata = ~o[31:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push2(input logic [63:0] o0, input logic [63:0] o1);
    in_valid  = 2'b11;
    in_rec[0] = mk_rec(o0);
    in_rec[1] = mk_rec(o1);
  endtask

  task automatic push_ch0(input logic [63:0] o0);
    in_valid  = 2'b01;
    in_rec[0] = mk_rec(o0);
    in_rec[1] = '0;
  endtask

  initial begin
    // reset
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = '0;
    in_rec    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_order", out_rec.order, 64'd0);
    chk("rst_out_pc", 64'(out_rec.pc_rdata), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_order_err", 64'(order_err), 64'd0);
    reset_n = 1'b1;
    tick();

    // two channels in one cycle, drained on consecutive cycles
    out_ready = 1'b1;
    push2(64'd1, 64'd2);
    tick();
    in_valid = '0;
    chk("dual_level", 64'(level), 64'd2);
    chk("dual_head1", out_rec.order, 64'd1);
    tick();
    chk("dual_head2", out_rec.order, 64'd2);
    chk("dual_err1", 64'(order_err), 64'd0);
    tick();
    chk("dual_err2", 64'(order_err), 64'd0);
    chk("dual_empty", 64'(out_valid), 64'd0);

    // only ch1 valid: no hole entry
    in_valid  = 2'b10;
    in_rec[0] = mk_rec(64'd99);
    in_rec[1] = mk_rec(64'd3);
    tick();
    in_valid = '0;
    chk("gap_level", 64'(level), 64'd1);
    chk("gap_order", out_rec.order, 64'd3);
    chk("gap_pc", 64'(out_rec.pc_rdata), 64'h8000_000c);
    tick();
    chk("gap_drained", 64'(level), 64'd0);
    chk("gap_err", 64'(order_err), 64'd0);

    // order discontinuity: pops 4,7,8
    out_ready = 1'b0;
    push2(64'd4, 64'd7);
    tick();
    push_ch0(64'd8);
    tick();
    in_valid = '0;
    chk("ord_level", 64'(level), 64'd3);
    out_ready = 1'b1;
    tick();
    chk("ord_err_4", 64'(order_err), 64'd0);
    chk("ord_head_7", out_rec.order, 64'd7);
    tick();
    chk("ord_err_7", 64'(order_err), 64'd1);
    tick();
    chk("ord_err_8", 64'(order_err), 64'd0);
    chk("ord_level_end", 64'(level), 64'd0);

    // fill to DEPTH across the pointer wrap, then overflow
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push2(64'(9 + 2 * i), 64'(10 + 2 * i));
      tick();
    end
    chk("full_level", 64'(level), 64'd16);
    chk("full_no_ovf", 64'(overflow), 64'd0);
    push2(64'd25, 64'd26);
    tick();
    chk("ovf_level", 64'(level), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    push2(64'd27, 64'd28);
    tick();
    in_valid = '0;
    chk("pp_level", 64'(level), 64'd16);
    chk("pp_ovf", 64'(overflow), 64'd1);
    chk("pp_head", out_rec.order, 64'd10);
    chk("pp_err", 64'(order_err), 64'd0);
    repeat (15) tick();
    chk("drain_level", 64'(level), 64'd1);
    chk("drain_head", out_rec.order, 64'd27);
    chk("drain_err", 64'(order_err), 64'd0);
    tick();
    chk("drain_err_27", 64'(order_err), 64'd1);
    chk("drain_empty", 64'(out_valid), 64'd0);
    tick();
    chk("drain_err_pulse", 64'(order_err), 64'd0);
    chk("empty_hold", 64'(level), 64'd0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    push2(64'd30, 64'd31);
    tick();
    push2(64'd32, 64'd33);
    tick();
    push_ch0(64'd34);
    tick();
    in_valid = '0;
    chk("mid_level", 64'(level), 64'd5);
    chk("mid_ovf_sticky", 64'(overflow), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    #3;
    reset_n = 1'b1;
    tick();

    // flush wins over simultaneous push/pop
    for (int i = 0; i < 9; i++) begin
      push2(64'(40 + 2 * i), 64'(41 + 2 * i));
      tick();
    end
    chk("pre_flush_level", 64'(level), 64'd16);
    chk("pre_flush_ovf", 64'(overflow), 64'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    push2(64'd90, 64'd91);
    tick();
    flush    = 1'b0;
    in_valid = '0;
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ovf", 64'(overflow), 64'd0);
    out_ready = 1'b0;
    push_ch0(64'd100);
    tick();
    in_valid = '0;
    chk("post_flush_level", 64'(level), 64'd1);
    chk("post_flush_head", out_rec.order, 64'd100);
    out_ready = 1'b1;
    tick();
    chk("post_flush_err", 64'(order_err), 64'd0);
    chk("post_flush_empty", 64'(level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
